// File: rtl/controle_vez_pkg.sv
// -----------------------------------------------------------------------------
// controle_vez_pkg
// Shared constants for the tic-tac-toe turn sequencer: FSM state encodings,
// player identifiers, board size and the highest legal cell index.
// No ports (package).
// -----------------------------------------------------------------------------
package controle_vez_pkg;

    // The encoding is visible on estado_db, so every value is fixed explicitly.
    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        LIMPA    = 3'b001,
        ESPERA   = 3'b010,
        ESCREVE  = 3'b011,
        VERIFICA = 3'b100,
        TROCA    = 3'b101,
        FIM      = 3'b110
    } estado_t;

    localparam logic     JOGADOR_1 = 1'b0;
    localparam logic     JOGADOR_2 = 1'b1;
    localparam int       NUM_CASAS = 9;
    localparam logic [3:0] CASA_MAX = 4'd8;

    // True when the requested index addresses a real board cell.
    function automatic logic casa_valida(input logic [3:0] pos);
        return pos <= CASA_MAX;
    endfunction

endpackage

// File: rtl/controle_vez_if.sv
// -----------------------------------------------------------------------------
// controle_vez_if
// Move handshake and board-memory strobes between the input logic / board
// memory side (master) and the turn sequencer (slave).
//   jogada_valida, posicao   : move request and requested cell
//   casa_ocupada, vitoria    : combinational board lookups fed back
//   posicao_reg, escreve_tab : captured address and write enable
//   limpa_tab                : board clear strobe
//   jogada_aceita/rejeitada  : handshake response
// -----------------------------------------------------------------------------
interface controle_vez_if;

    logic       jogada_valida;
    logic [3:0] posicao;
    logic       casa_ocupada;
    logic       vitoria;
    logic [3:0] posicao_reg;
    logic       escreve_tab;
    logic       limpa_tab;
    logic       jogada_aceita;
    logic       jogada_rejeitada;

    modport master (
        output jogada_valida, posicao, casa_ocupada, vitoria,
        input  posicao_reg, escreve_tab, limpa_tab, jogada_aceita, jogada_rejeitada
    );

    modport slave (
        input  jogada_valida, posicao, casa_ocupada, vitoria,
        output posicao_reg, escreve_tab, limpa_tab, jogada_aceita, jogada_rejeitada
    );

endinterface

// File: rtl/controle_vez_contador_m.sv
// -----------------------------------------------------------------------------
// contador_m
// Mod-M up counter used as the per-turn timer.
//   clock, reset_n : clock and async active-low reset
//   zera           : synchronous clear (wins over conta)
//   conta          : count enable
//   fim            : count is at its terminal value M-1
// -----------------------------------------------------------------------------
module contador_m #(
    parameter int M = 5000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            if (q == W'(M - 1)) q <= '0;
            else                q <= q + 1'b1;
        end
    end

    assign fim = (q == W'(M - 1));

endmodule

// File: rtl/controle_vez.sv
// -----------------------------------------------------------------------------
// controle_vez
// Turn sequencer for tic-tac-toe: alternates players, accepts or rejects move
// requests, strobes the board memory, and decides win, draw or timeout.
//   clock, reset_n  : clock and async active-low reset
//   iniciar         : start/restart, honoured in IDLE and FIM only
//   bus (slave)     : move handshake and board strobes (see controle_vez_if)
//   jogador         : active player (0 = player 1, 1 = player 2)
//   num_jogadas     : moves played, saturating at NUM_CASAS
//   fim_jogo        : game over level
//   vencedor        : winner, valid when fim_jogo=1 and empate=0
//   empate, timeout : draw / time-forfeit result flags
//   estado_db       : current FSM state
// -----------------------------------------------------------------------------
module controle_vez
    import controle_vez_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int NUM_CASAS      = controle_vez_pkg::NUM_CASAS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 iniciar,
    controle_vez_if.slave        bus,
    output logic                 jogador,
    output logic [3:0]           num_jogadas,
    output logic                 fim_jogo,
    output logic                 vencedor,
    output logic                 empate,
    output logic                 timeout,
    output logic [2:0]           estado_db
);

    estado_t    estado;
    logic [3:0] posicao_r;
    logic       escreve_r;
    logic       limpa_r;
    logic       aceita_r;
    logic       rejeita_r;

    logic timer_zera;
    logic timer_conta;
    logic timer_fim;
    logic jogada_legal;

    // The timer restarts on every new turn and only runs while waiting for a
    // move; it is frozen through ESCREVE/VERIFICA and in FIM.
    assign timer_zera  = (estado == LIMPA) || (estado == TROCA);
    assign timer_conta = (estado == ESPERA);

    contador_m #(
        .M (TIMEOUT_CICLOS)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .zera    (timer_zera),
        .conta   (timer_conta),
        .fim     (timer_fim)
    );

    assign jogada_legal = bus.jogada_valida && casa_valida(bus.posicao) && !bus.casa_ocupada;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= IDLE;
            posicao_r   <= '0;
            escreve_r   <= 1'b0;
            limpa_r     <= 1'b0;
            aceita_r    <= 1'b0;
            rejeita_r   <= 1'b0;
            jogador     <= JOGADOR_1;
            num_jogadas <= '0;
            fim_jogo    <= 1'b0;
            vencedor    <= 1'b0;
            empate      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            // Strobes are registered from the transition into their state, so
            // they default low and are raised only on that transition.
            escreve_r <= 1'b0;
            limpa_r   <= 1'b0;
            aceita_r  <= 1'b0;
            rejeita_r <= 1'b0;

            case (estado)
                IDLE: begin
                    if (iniciar) begin
                        estado  <= LIMPA;
                        limpa_r <= 1'b1;
                    end
                end

                LIMPA: begin
                    jogador     <= JOGADOR_1;
                    num_jogadas <= '0;
                    fim_jogo    <= 1'b0;
                    vencedor    <= 1'b0;
                    empate      <= 1'b0;
                    timeout     <= 1'b0;
                    estado      <= ESPERA;
                end

                ESPERA: begin
                    // A legal move on the terminal timer cycle beats the timeout.
                    if (jogada_legal) begin
                        posicao_r <= bus.posicao;
                        escreve_r <= 1'b1;
                        aceita_r  <= 1'b1;
                        estado    <= ESCREVE;
                    end else begin
                        if (bus.jogada_valida) rejeita_r <= 1'b1;
                        if (timer_fim) begin
                            fim_jogo <= 1'b1;
                            timeout  <= 1'b1;
                            vencedor <= ~jogador;
                            estado   <= FIM;
                        end
                    end
                end

                ESCREVE: begin
                    if (num_jogadas != 4'(NUM_CASAS)) num_jogadas <= num_jogadas + 4'd1;
                    estado <= VERIFICA;
                end

                VERIFICA: begin
                    // Win is checked first so a winning ninth move is not a draw.
                    if (bus.vitoria) begin
                        fim_jogo <= 1'b1;
                        vencedor <= jogador;
                        estado   <= FIM;
                    end else if (num_jogadas == 4'(NUM_CASAS)) begin
                        fim_jogo <= 1'b1;
                        empate   <= 1'b1;
                        estado   <= FIM;
                    end else begin
                        estado <= TROCA;
                    end
                end

                TROCA: begin
                    jogador <= (jogador == JOGADOR_1) ? JOGADOR_2 : JOGADOR_1;
                    estado  <= ESPERA;
                end

                FIM: begin
                    if (iniciar) begin
                        estado  <= LIMPA;
                        limpa_r <= 1'b1;
                    end
                end

                default: estado <= IDLE;
            endcase
        end
    end

    assign bus.posicao_reg      = posicao_r;
    assign bus.escreve_tab      = escreve_r;
    assign bus.limpa_tab        = limpa_r;
    assign bus.jogada_aceita    = aceita_r;
    assign bus.jogada_rejeitada = rejeita_r;
    assign estado_db            = estado;

endmodule
